// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the ALU scheduler: ALU control codes, the FSM encoding,
// and the check that decides whether an operation may be sent to the ALU.
package alu_scheduler_pkg;

    // ALU control codes, shared with the ALU control unit
    localparam logic [3:0] AluAnd  = 4'b0000;
    localparam logic [3:0] AluOr   = 4'b0001;
    localparam logic [3:0] AluAdd  = 4'b0010;
    localparam logic [3:0] AluSub  = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSll  = 4'b0101;
    localparam logic [3:0] AluSrl  = 4'b0110;
    localparam logic [3:0] AluSltu = 4'b0111;
    localparam logic [3:0] AluMul  = 4'b1000;
    localparam logic [3:0] AluDiv  = 4'b1001;
    localparam logic [3:0] AluRem  = 4'b1010;
    localparam logic [3:0] AluNor  = 4'b1011;
    localparam logic [3:0] AluPass = 4'b1100;

    localparam logic [3:0] AluLastLegal = AluPass;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

    // An erroring op never reaches the ALU
    function automatic logic op_is_err(input logic [3:0] op, input logic b_is_zero);
        return (op > AluLastLegal) || ((op == AluDiv) && b_is_zero);
    endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Request/response channel between the two requesters and the ALU scheduler.
// Requester i owns bit i of each vector and slice i of the packed op/operand buses.
interface alu_scheduler_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [7:0]         req_op;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [WIDTH-1:0]   rsp_result;
    logic               rsp_zero;
    logic               rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a tie and
// flips to the other requester only when a grant is actually taken.
module rr_arbiter2 (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [1:0] i_valid,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_ptr;

    always_comb begin
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            o_grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two requesters: accepts one op at a time,
// drives the ALU from registers for a single cycle, and returns the result to its owner.
module alu_scheduler
    import alu_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    alu_scheduler_if.slave   bus,
    output logic [3:0]       o_alu_op,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    input  logic [WIDTH-1:0] i_alu_result
);

    state_e           r_state;
    state_e           w_state_next;
    logic [1:0]       w_grant;
    logic             w_accept;
    logic [3:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_sel_err;

    logic             r_owner;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;
    logic [3:0]       r_alu_op;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;

    rr_arbiter2 u_arb (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_valid   (bus.req_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    assign w_accept  = (r_state == StIdle) && (w_grant != 2'b00);
    assign w_sel_op  = w_grant[1] ? bus.req_op[7:4] : bus.req_op[3:0];
    assign w_sel_a   = w_grant[1] ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
    assign w_sel_b   = w_grant[1] ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
    assign w_sel_err = op_is_err(w_sel_op, w_sel_b == '0);

    always_comb begin
        w_state_next  = r_state;
        bus.req_ready = 2'b00;
        bus.rsp_valid = 2'b00;
        unique case (r_state)
            StIdle: begin
                bus.req_ready = w_grant;
                if (w_grant != 2'b00) begin
                    w_state_next = w_sel_err ? StResp : StExec;
                end
            end
            StExec: w_state_next = StResp;
            StResp: begin
                bus.rsp_valid = r_owner ? 2'b10 : 2'b01;
                if (bus.rsp_ready[r_owner]) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // ALU registers load only for ops that will execute, so they hold otherwise
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_owner  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
            r_alu_op <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_owner <= w_grant[1];
                if (w_sel_err) begin
                    r_result <= '0;
                    r_zero   <= 1'b1;
                    r_err    <= 1'b1;
                end else begin
                    r_alu_op <= w_sel_op;
                    r_alu_a  <= w_sel_a;
                    r_alu_b  <= w_sel_b;
                end
            end
            // The ALU's own zero flag lags, so derive it from the captured result
            if (r_state == StExec) begin
                r_result <= i_alu_result;
                r_zero   <= (i_alu_result == '0);
                r_err    <= 1'b0;
            end
        end
    end

    assign bus.rsp_result = r_result;
    assign bus.rsp_zero   = r_zero;
    assign bus.rsp_err    = r_err;
    assign o_alu_op       = r_alu_op;
    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a behavioural ALU model on the ALU side.
module tb_alu_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    int          n_checks;
    int          n_fail;

    alu_scheduler_if #(.WIDTH(32)) bus ();

    alu_scheduler #(.WIDTH(32)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .bus          (bus),
        .o_alu_op     (alu_op),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .i_alu_result (alu_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0011: alu_result = alu_a - alu_b;
            4'b0100: alu_result = alu_a ^ alu_b;
            4'b0101: alu_result = (alu_b >= 32) ? 32'd0 : alu_a << alu_b[4:0];
            4'b0110: alu_result = (alu_b >= 32) ? 32'd0 : alu_a >> alu_b[4:0];
            4'b0111: alu_result = {31'd0, alu_a < alu_b};
            4'b1000: alu_result = alu_a * alu_b;
            4'b1001: alu_result = (alu_b == 0) ? 32'hffff_ffff : alu_a / alu_b;
            4'b1010: alu_result = (alu_b == 0) ? alu_a : alu_a % alu_b;
            4'b1011: alu_result = ~(alu_a | alu_b);
            4'b1100: alu_result = alu_b;
            default: alu_result = 32'd0;
        endcase
    end

    task automatic idle_inputs();
        bus.req_valid = 2'b00;
        bus.req_op    = 8'd0;
        bus.req_a     = 64'd0;
        bus.req_b     = 64'd0;
        bus.rsp_ready = 2'b00;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        bus.req_op[4*r +: 4] = op;
        bus.req_a[32*r +: 32] = a;
        bus.req_b[32*r +: 32] = b;
    endtask

    // Issues one op with rsp_ready high and reports the response; lat counts
    // negedges from the accepting edge to rsp_valid, -1 if none came.
    task automatic run_op(input int r, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [1:0] rv, output logic [31:0] res,
                          output logic z, output logic e, output int lat);
        int k;
        @(negedge clk);
        set_req(r, op, a, b);
        bus.req_valid = (r == 0) ? 2'b01 : 2'b10;
        bus.rsp_ready = 2'b11;
        k = 0;
        #1;
        while (bus.req_ready == 2'b00 && k < 10) begin
            @(negedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        lat = -1;
        rv  = 2'b00;
        res = 32'd0;
        z   = 1'b0;
        e   = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) begin
                lat = c;
                rv  = bus.rsp_valid;
                res = bus.rsp_result;
                z   = bus.rsp_zero;
                e   = bus.rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b, want 00 00",
                     bus.req_ready, bus.rsp_valid);
        end
        n_checks++;
        if (bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: result=%h zero=%b err=%b, want 0 0 0",
                     bus.rsp_result, bus.rsp_zero, bus.rsp_err);
        end
        n_checks++;
        if (alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_alu: op=%h a=%h b=%h, want 0 0 0", alu_op, alu_a, alu_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        apply_reset();
        set_req(0, 4'b0010, 32'd5, 32'd7);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b11;
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 01", bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if (alu_op !== 4'b0010 || alu_a !== 32'd5 || alu_b !== 32'd7 || bus.rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL single_exec: op=%h a=%0d b=%0d rsp_valid=%b, want 2 5 7 00",
                     alu_op, alu_a, alu_b, bus.rsp_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd12 || bus.rsp_zero !== 1'b0 ||
            bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp: valid=%b result=%0d zero=%b err=%b, want 01 12 0 0",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_err);
        end
        bus.req_valid = 2'b01;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL single_next_accept: rsp_valid=%b req_ready=%b, want 00 01",
                     bus.rsp_valid, bus.req_ready);
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_both_valid();
        apply_reset();
        set_req(0, 4'b0011, 32'd9, 32'd9);
        set_req(1, 4'b1000, 32'd6, 32'd7);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL both_grant0: got %b want 01", bus.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 2'b00 || alu_op !== 4'b0011) begin
            n_fail++;
            $display("FAIL both_exec0: req_ready=%b alu_op=%h, want 00 3", bus.req_ready, alu_op);
        end
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL both_rsp0: valid=%b result=%0d zero=%b, want 01 0 1",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_zero);
        end
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL both_grant1: got %b want 10", bus.req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 32'd42 || bus.rsp_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL both_rsp1: valid=%b result=%0d zero=%b, want 10 42 0",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_zero);
        end
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL both_grant2: got %b want 01", bus.req_ready);
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_div_zero();
        logic [1:0]  rv;
        logic [31:0] res;
        logic        z;
        logic        e;
        int          lat;
        apply_reset();
        run_op(1, 4'b0100, 32'h0000_00f0, 32'h0000_003c, rv, res, z, e, lat);
        n_checks++;
        if (rv !== 2'b10 || res !== 32'h0000_00cc || e !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("FAIL xor_rsp: valid=%b result=%h err=%b lat=%0d, want 10 cc 0 2",
                     rv, res, e, lat);
        end
        run_op(1, 4'b1001, 32'd10, 32'd0, rv, res, z, e, lat);
        n_checks++;
        if (rv !== 2'b10 || res !== 32'd0 || e !== 1'b1 || z !== 1'b1 || lat != 1) begin
            n_fail++;
            $display("FAIL divzero_rsp: valid=%b result=%h err=%b zero=%b lat=%0d, want 10 0 1 1 1",
                     rv, res, e, z, lat);
        end
        n_checks++;
        if (alu_op !== 4'b0100 || alu_a !== 32'h0000_00f0 || alu_b !== 32'h0000_003c) begin
            n_fail++;
            $display("FAIL divzero_alu_hold: op=%h a=%h b=%h, want 4 f0 3c", alu_op, alu_a, alu_b);
        end
        run_op(1, 4'b1001, 32'd100, 32'd7, rv, res, z, e, lat);
        n_checks++;
        if (rv !== 2'b10 || res !== 32'd14 || e !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("FAIL div_rsp: valid=%b result=%0d err=%b lat=%0d, want 10 14 0 2",
                     rv, res, e, lat);
        end
    endtask

    task automatic test_illegal_op();
        logic [1:0]  rv;
        logic [31:0] res;
        logic        z;
        logic        e;
        int          lat;
        apply_reset();
        run_op(0, 4'b1110, 32'd11, 32'd22, rv, res, z, e, lat);
        n_checks++;
        if (rv !== 2'b01 || res !== 32'd0 || e !== 1'b1 || lat != 1) begin
            n_fail++;
            $display("FAIL illegal_rsp: valid=%b result=%h err=%b lat=%0d, want 01 0 1 1",
                     rv, res, e, lat);
        end
        run_op(0, 4'b0011, 32'd20, 32'd5, rv, res, z, e, lat);
        n_checks++;
        if (rv !== 2'b01 || res !== 32'd15 || e !== 1'b0 || z !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("FAIL after_illegal_rsp: valid=%b result=%0d err=%b zero=%b lat=%0d, want 01 15 0 0 2",
                     rv, res, e, z, lat);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_req(0, 4'b1000, 32'd3, 32'd5);
        set_req(1, 4'b0000, 32'd1, 32'd1);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b00;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd15 || bus.rsp_err !== 1'b0 ||
                bus.req_ready !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: valid=%b result=%0d err=%b req_ready=%b, want 01 15 0 00",
                         i, bus.rsp_valid, bus.rsp_result, bus.rsp_err, bus.req_ready);
            end
            // Non-owner readiness must not release the response
            bus.rsp_ready = (i >= 2) ? 2'b10 : 2'b00;
        end
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: rsp_valid=%b req_ready=%b, want 00 10",
                     bus.rsp_valid, bus.req_ready);
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_reset_exec();
        logic [1:0]  rv;
        logic [31:0] res;
        logic        z;
        logic        e;
        int          lat;
        apply_reset();
        set_req(1, 4'b0010, 32'd100, 32'd1);
        bus.req_valid = 2'b10;
        bus.rsp_ready = 2'b11;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if (alu_op !== 4'b0010 || alu_a !== 32'd100) begin
            n_fail++;
            $display("FAIL rexec_in_exec: alu_op=%h alu_a=%0d, want 2 100", alu_op, alu_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00 || bus.rsp_result !== 32'd0 ||
            bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0 || alu_op !== 4'd0 ||
            alu_a !== 32'd0 || alu_b !== 32'd0) begin
            n_fail++;
            $display("FAIL rexec_after_reset: rsp_valid=%b req_ready=%b result=%h zero=%b err=%b op=%h a=%h b=%h",
                     bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_zero, bus.rsp_err,
                     alu_op, alu_a, alu_b);
        end
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL rexec_no_rsp: rsp_valid=%b want 00", bus.rsp_valid);
        end
        run_op(1, 4'b0010, 32'd100, 32'd1, rv, res, z, e, lat);
        n_checks++;
        if (rv !== 2'b10 || res !== 32'd101 || e !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("FAIL rexec_follow: valid=%b result=%0d err=%b lat=%0d, want 10 101 0 2",
                     rv, res, e, lat);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_single_add();
        test_both_valid();
        test_div_zero();
        test_illegal_op();
        test_backpressure();
        test_reset_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
